shim_shutdown_sense_mux: RTL

SHIM_SHUTDOWN_SENSE_MUX -- requirements
Module: shim_shutdown_sense_mux

---
 rtl/shim_shutdown_sense_mux.sv | 102 ++++++++++
 1 files changed

// File: rtl/shim_shutdown_sense_mux.sv
// Shutdown-fault sense mux: 8 synchronized, debounced fault channels muxed onto one pin.
// Optional sticky fault holding is enabled by defining SHUTDOWN_SENSE_STICKY_EN.
module shim_shutdown_sense_mux #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MUX_DELAY       = 1
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] fault_in,
    input  logic [2:0] sense_sel,
    input  logic       fault_clear,
    output logic       shutdown_sense_pin,
    output logic [7:0] fault_status
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]           sync_q1;
    logic [7:0]           sync_q2;
    logic [CW-1:0]        cnt_q [8];
    logic [7:0]           level_q;
    logic [7:0]           flip;
    logic [7:0]           rise;
    logic [MUX_DELAY-1:0] pipe_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= fault_in;
            sync_q2 <= sync_q1;
        end
    end

    // A channel flips when its counter would reach DEBOUNCE_CYCLES on this edge.
    always_comb begin
        flip = '0;
        rise = '0;
        for (int i = 0; i < 8; i++) begin
            flip[i] = (sync_q2[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
            rise[i] = flip[i] && !level_q[i];
        end
    end

    // NOTE: the counter array is a set of flops, not RAM, so every element takes the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            level_q <= '0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_q ^ flip;
            for (int i = 0; i < 8; i++) begin
                if (sync_q2[i] == level_q[i] || flip[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

`ifdef SHUTDOWN_SENSE_STICKY_EN
    logic [7:0] held_q;

    // Set wins over clear; a clear only drops bits whose debounced level is already low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            held_q <= '0;
        end else begin
            held_q <= rise | (held_q & ~({8{fault_clear}} & ~level_q));
        end
    end

    assign fault_status = held_q;
`else
    logic       unused_fault_clear;
    logic [7:0] unused_rise;

    assign unused_fault_clear = fault_clear;
    assign unused_rise        = rise;
    assign fault_status       = level_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= fault_status[sense_sel];
            for (int k = 1; k < MUX_DELAY; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign shutdown_sense_pin = pipe_q[MUX_DELAY-1];

endmodule
